// File: rtl/heeperator_fpga_pkg.sv
// Shared types for the HEEPerator FPGA wrapper: reset sequencer states and reset causes.
package heeperator_fpga_pkg;

  typedef enum logic [1:0] {
    ASSERT = 2'b00,
    HOLD   = 2'b01,
    RUN    = 2'b10
  } rst_seq_state_e;

  typedef enum logic [1:0] {
    POR  = 2'b00,
    BTN  = 2'b01,
    LOCK = 2'b10
  } rst_cause_e;

endpackage

// File: rtl/xilinx_btn_debouncer.sv
// Board reset button conditioning: input synchronizer, stable-level debounce counter,
// and a one-cycle pulse on each accepted press (0->1 debounced edge).
module xilinx_btn_debouncer #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic btn_db_o,
  output logic btn_press_o
);

  localparam int unsigned DB_CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DB_CNT_W-1:0]    r_db_cnt;
  logic                   r_btn_db;
  logic                   r_press;
  logic                   w_btn_s;

  assign w_btn_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], btn_i};
    end
  end

  // Debounced level resets to "pressed" so the core stays in reset until the button reads released.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_db_cnt <= '0;
      r_btn_db <= 1'b1;
      r_press  <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (w_btn_s == r_btn_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_db_cnt <= '0;
        r_btn_db <= w_btn_s;
        r_press  <= w_btn_s;
      end else begin
        r_db_cnt <= r_db_cnt + DB_CNT_W'(1);
      end
    end
  end

  assign btn_db_o    = r_btn_db;
  assign btn_press_o = r_press;

endmodule

// File: rtl/xilinx_rst_sequencer.sv
// Reset sequencer for the HEEPerator FPGA top: combines the debounced button and the
// synchronized PLL lock into a held, registered active-low core reset with cause reporting.
module xilinx_rst_sequencer
  import heeperator_fpga_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned HOLD_CYCLES     = 256
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       btn_rst_i,
  input  logic       pll_locked_i,
  output logic       rst_no,
  output logic       rst_led_o,
  output logic [1:0] state_o,
  output logic [1:0] rst_cause_o,
  output logic       btn_press_o
);

  localparam int unsigned HOLD_CNT_W = $clog2(HOLD_CYCLES + 1);

  logic [SYNC_STAGES-1:0] r_lock_sync;
  logic [HOLD_CNT_W-1:0]  r_hold_cnt;
  logic [HOLD_CNT_W-1:0]  w_hold_cnt_nxt;
  rst_seq_state_e         r_state;
  rst_seq_state_e         w_state_nxt;
  rst_cause_e             r_cause;
  rst_cause_e             w_cause_nxt;
  logic                   r_rst_n;
  logic                   w_lock_s;
  logic                   w_btn_db;
  logic                   w_btn_press;
  logic                   w_go;

  xilinx_btn_debouncer #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debouncer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .btn_i      (btn_rst_i),
    .btn_db_o   (w_btn_db),
    .btn_press_o(w_btn_press)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_lock_sync <= '0;
    end else begin
      r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], pll_locked_i};
    end
  end

  assign w_lock_s = r_lock_sync[SYNC_STAGES-1];
  assign w_go     = w_lock_s & ~w_btn_db;

  always_comb begin
    w_state_nxt    = r_state;
    w_hold_cnt_nxt = r_hold_cnt;
    w_cause_nxt    = r_cause;
    case (r_state)
      ASSERT: begin
        if (w_go) begin
          w_state_nxt    = HOLD;
          w_hold_cnt_nxt = '0;
        end
      end
      HOLD: begin
        if (!w_go) begin
          w_state_nxt = ASSERT;
        end else if (r_hold_cnt == HOLD_CNT_W'(HOLD_CYCLES - 1)) begin
          w_state_nxt = RUN;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + HOLD_CNT_W'(1);
        end
      end
      RUN: begin
        // Lock loss outranks a button press landing in the same cycle.
        if (!w_lock_s) begin
          w_state_nxt = ASSERT;
          w_cause_nxt = LOCK;
        end else if (w_btn_press) begin
          w_state_nxt = ASSERT;
          w_cause_nxt = BTN;
        end
      end
      default: begin
        w_state_nxt = ASSERT;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= ASSERT;
      r_hold_cnt <= '0;
      r_cause    <= POR;
      r_rst_n    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_cause    <= w_cause_nxt;
      r_rst_n    <= (w_state_nxt == RUN);
    end
  end

  assign rst_no      = r_rst_n;
  assign rst_led_o   = r_rst_n;
  assign state_o     = r_state;
  assign rst_cause_o = r_cause;
  assign btn_press_o = w_btn_press;

endmodule

// File: tb/tb_xilinx_rst_sequencer.sv
// Directed bench for xilinx_rst_sequencer with SYNC_STAGES=2, DEBOUNCE_CYCLES=8, HOLD_CYCLES=16.
module tb_xilinx_rst_sequencer;

  localparam logic [31:0] S_ASSERT = 32'd0;
  localparam logic [31:0] S_HOLD   = 32'd1;
  localparam logic [31:0] S_RUN    = 32'd2;
  localparam logic [31:0] C_POR    = 32'd0;
  localparam logic [31:0] C_BTN    = 32'd1;
  localparam logic [31:0] C_LOCK   = 32'd2;

  logic       clk;
  logic       rst_ni;
  logic       btn_rst_i;
  logic       pll_locked_i;
  logic       rst_no;
  logic       rst_led_o;
  logic [1:0] state_o;
  logic [1:0] rst_cause_o;
  logic       btn_press_o;

  int checks = 0;
  int errors = 0;
  int n_press = 0;
  int n_high = 0;

  xilinx_rst_sequencer #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(8),
    .HOLD_CYCLES    (16)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .btn_rst_i   (btn_rst_i),
    .pll_locked_i(pll_locked_i),
    .rst_no      (rst_no),
    .rst_led_o   (rst_led_o),
    .state_o     (state_o),
    .rst_cause_o (rst_cause_o),
    .btn_press_o (btn_press_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n clock edges, sampling on the falling edge and tallying press pulses / rst_no high.
  task automatic watch(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (btn_press_o === 1'b1) n_press++;
      if (rst_no === 1'b1) n_high++;
    end
  endtask

  task automatic clear_counts();
    n_press = 0;
    n_high  = 0;
  endtask

  initial begin
    rst_ni       = 1'b0;
    btn_rst_i    = 1'b0;
    pll_locked_i = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_rst_no", rst_no, 0);
    check("rst_led", rst_led_o, 0);
    check("rst_state", state_o, S_ASSERT);
    check("rst_cause", rst_cause_o, C_POR);
    check("rst_press", btn_press_o, 0);

    // Power-up
    rst_ni = 1'b1;
    clear_counts();
    watch(8);
    check("pu_state_e8", state_o, S_ASSERT);
    watch(1);
    check("pu_state_e9", state_o, S_HOLD);
    watch(15);
    check("pu_state_e24", state_o, S_HOLD);
    check("pu_rst_no_e24", rst_no, 0);
    check("pu_high_before_run", n_high, 0);
    watch(1);
    check("pu_state_e25", state_o, S_RUN);
    check("pu_rst_no_e25", rst_no, 1);
    check("pu_led_e25", rst_led_o, 1);
    check("pu_cause", rst_cause_o, C_POR);
    check("pu_no_press", n_press, 0);

    // Bounce while running
    clear_counts();
    for (int i = 0; i < 40; i++) begin
      btn_rst_i = (((i / 3) % 2) == 0);
      watch(1);
    end
    btn_rst_i = 1'b0;
    watch(10);
    check("bounce_press", n_press, 0);
    check("bounce_high", n_high, 50);
    check("bounce_state", state_o, S_RUN);

    // Button press held for 20 cycles
    clear_counts();
    btn_rst_i = 1'b1;
    watch(9);
    check("btn_no_press_yet", n_press, 0);
    check("btn_state_e9", state_o, S_RUN);
    watch(1);
    check("btn_press_e10", btn_press_o, 1);
    check("btn_rst_no_e10", rst_no, 1);
    watch(1);
    check("btn_press_e11", btn_press_o, 0);
    check("btn_state_e11", state_o, S_ASSERT);
    check("btn_rst_no_e11", rst_no, 0);
    check("btn_cause", rst_cause_o, C_BTN);
    watch(9);
    check("btn_held_state", state_o, S_ASSERT);
    check("btn_single_pulse", n_press, 1);
    btn_rst_i = 1'b0;
    clear_counts();
    watch(26);
    check("btn_rel_state_r26", state_o, S_HOLD);
    check("btn_rel_high", n_high, 0);
    watch(1);
    check("btn_rel_state_r27", state_o, S_RUN);
    check("btn_rel_rst_no_r27", rst_no, 1);
    check("btn_rel_cause", rst_cause_o, C_BTN);
    check("btn_rel_no_press", n_press, 0);

    // Single-cycle lock loss
    pll_locked_i = 1'b0;
    watch(1);
    pll_locked_i = 1'b1;
    watch(1);
    check("lock_state_l2", state_o, S_RUN);
    check("lock_rst_no_l2", rst_no, 1);
    watch(1);
    check("lock_state_l3", state_o, S_ASSERT);
    check("lock_rst_no_l3", rst_no, 0);
    check("lock_cause", rst_cause_o, C_LOCK);
    watch(1);
    check("lock_state_l4", state_o, S_HOLD);
    watch(15);
    check("lock_state_l19", state_o, S_HOLD);
    check("lock_rst_no_l19", rst_no, 0);
    watch(1);
    check("lock_state_l20", state_o, S_RUN);
    check("lock_rst_no_l20", rst_no, 1);
    check("lock_cause_kept", rst_cause_o, C_LOCK);

    // HOLD abort during recovery from a button reset
    btn_rst_i = 1'b1;
    watch(11);
    check("abort_state_pre", state_o, S_ASSERT);
    check("abort_cause_pre", rst_cause_o, C_BTN);
    watch(9);
    btn_rst_i = 1'b0;
    clear_counts();
    watch(19);
    check("abort_state_r19", state_o, S_HOLD);
    pll_locked_i = 1'b0;
    watch(2);
    check("abort_state_r21", state_o, S_HOLD);
    watch(1);
    check("abort_state_r22", state_o, S_ASSERT);
    check("abort_cause_r22", rst_cause_o, C_BTN);
    watch(3);
    pll_locked_i = 1'b1;
    watch(2);
    check("abort_state_r27", state_o, S_ASSERT);
    watch(1);
    check("abort_state_r28", state_o, S_HOLD);
    watch(15);
    check("abort_state_r43", state_o, S_HOLD);
    check("abort_high", n_high, 0);
    watch(1);
    check("abort_state_r44", state_o, S_RUN);
    check("abort_rst_no_r44", rst_no, 1);
    check("abort_cause_final", rst_cause_o, C_BTN);

    // Lock loss and button press resolve in the same cycle
    btn_rst_i = 1'b1;
    watch(8);
    pll_locked_i = 1'b0;
    watch(2);
    check("sim_press", btn_press_o, 1);
    check("sim_state_e10", state_o, S_RUN);
    watch(1);
    check("sim_state_e11", state_o, S_ASSERT);
    check("sim_cause", rst_cause_o, C_LOCK);
    check("sim_rst_no", rst_no, 0);
    btn_rst_i    = 1'b0;
    pll_locked_i = 1'b1;
    watch(26);
    check("sim_state_e37", state_o, S_HOLD);
    watch(1);
    check("sim_state_e38", state_o, S_RUN);
    check("sim_rst_no_e38", rst_no, 1);

    // Block reset pulsed mid-RUN
    rst_ni = 1'b0;
    watch(1);
    check("mrun_rst_no", rst_no, 0);
    check("mrun_led", rst_led_o, 0);
    check("mrun_state", state_o, S_ASSERT);
    check("mrun_cause", rst_cause_o, C_POR);
    check("mrun_press", btn_press_o, 0);
    rst_ni = 1'b1;
    watch(9);
    check("mhold_state_pre", state_o, S_HOLD);

    // Block reset pulsed mid-HOLD
    rst_ni = 1'b0;
    watch(1);
    check("mhold_state", state_o, S_ASSERT);
    check("mhold_rst_no", rst_no, 0);
    rst_ni = 1'b1;
    watch(24);
    check("mhold_state_e24", state_o, S_HOLD);
    watch(1);
    check("mhold_state_e25", state_o, S_RUN);
    check("mhold_rst_no_e25", rst_no, 1);
    check("mhold_cause", rst_cause_o, C_POR);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
